// File: rtl/sof_tap_scanner_if.sv
// rtl/sof_tap_scanner_if.sv - control/status bundle between the aligner controller and the tap scanner
interface sof_tap_scanner_if;
  logic       enable;
  logic       sof_aligned;
  logic       force_tap_en;
  logic [3:0] force_tap;
  logic       relock_req;
  logic [3:0] tap;
  logic       locked;
  logic       scan_fail;
  logic [7:0] relock_cnt;
  logic [1:0] state;

  // Driver side: supplies the control inputs and observes the scanner status
  modport master (
    output enable, sof_aligned, force_tap_en, force_tap, relock_req,
    input  tap, locked, scan_fail, relock_cnt, state
  );

  // Scanner side
  modport slave (
    input  enable, sof_aligned, force_tap_en, force_tap, relock_req,
    output tap, locked, scan_fail, relock_cnt, state
  );
endinterface

// File: rtl/sof_tap_scanner.sv
// rtl/sof_tap_scanner.sv - SOF tap sweep, lock detection and loss-of-lock rescan FSM
module sof_tap_scanner #(
  parameter int SETTLE_CYCLES = 4,
  parameter int LOCK_COUNT    = 8,
  parameter int ERR_THRESH    = 2
) (
  input  logic               clock,
  input  logic               reset_i,
  sof_tap_scanner_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] ERR_LAST    = 8'(ERR_THRESH - 1);

  state_t     state_q, state_d;
  logic [3:0] tap_q, tap_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] good_q, good_d;
  logic [7:0] err_q, err_d;
  logic [4:0] tries_q, tries_d;
  logic       fail_q, fail_d;
  logic [7:0] relock_q, relock_d;
  logic [7:0] relock_inc;
  logic       locked_q;
  logic [1:0] rst_sync;
  logic       rst_core;

  // Reset asserts at once but releases only after two clean clock edges
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) rst_sync <= 2'b11;
    else         rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_core   = rst_sync[1];
  assign relock_inc = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

  // Next-state and counter logic, evaluated in input-priority order
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    settle_d = settle_q;
    good_d   = good_q;
    err_d    = err_q;
    tries_d  = tries_q;
    fail_d   = fail_q;
    relock_d = relock_q;

    if (!bus.enable) begin
      state_d  = IDLE;
      tap_d    = 4'd0;
      settle_d = 4'd0;
      good_d   = 8'd0;
      err_d    = 8'd0;
      tries_d  = 5'd0;
      fail_d   = 1'b0;
    end else if (bus.force_tap_en) begin
      if (state_q == LOCKED) relock_d = relock_inc;
      state_d  = SETTLE;
      tap_d    = bus.force_tap;
      settle_d = 4'd0;
      good_d   = 8'd0;
      err_d    = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          settle_d = 4'd0;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = CHECK;
            settle_d = 4'd0;
            good_d   = 8'd0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        CHECK: begin
          if (bus.sof_aligned) begin
            if (good_q == LOCK_LAST) begin
              state_d = LOCKED;
              fail_d  = 1'b0;
              tries_d = 5'd0;
              err_d   = 8'd0;
            end else begin
              good_d = good_q + 8'd1;
            end
          end else begin
            state_d  = SETTLE;
            tap_d    = tap_q + 4'd1;
            settle_d = 4'd0;
            good_d   = 8'd0;
            if (tries_q == 5'd15) begin
              tries_d = 5'd0;
              fail_d  = 1'b1;
            end else begin
              tries_d = tries_q + 5'd1;
            end
          end
        end
        LOCKED: begin
          if (bus.relock_req || (!bus.sof_aligned && err_q == ERR_LAST)) begin
            state_d  = SETTLE;
            tap_d    = tap_q + 4'd1;
            settle_d = 4'd0;
            err_d    = 8'd0;
            relock_d = relock_inc;
          end else if (!bus.sof_aligned) begin
            err_d = err_q + 8'd1;
          end else begin
            err_d = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clock or posedge rst_core) begin
    if (rst_core) begin
      state_q  <= IDLE;
      tap_q    <= 4'd0;
      settle_q <= 4'd0;
      good_q   <= 8'd0;
      err_q    <= 8'd0;
      tries_q  <= 5'd0;
      fail_q   <= 1'b0;
      relock_q <= 8'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      settle_q <= settle_d;
      good_q   <= good_d;
      err_q    <= err_d;
      tries_q  <= tries_d;
      fail_q   <= fail_d;
      relock_q <= relock_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign bus.tap        = tap_q;
  assign bus.locked     = locked_q;
  assign bus.scan_fail  = fail_q;
  assign bus.relock_cnt = relock_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_sof_tap_scanner.sv
// tb/tb_sof_tap_scanner.sv - randomized and directed bench for sof_tap_scanner
module tb_sof_tap_scanner;
  localparam int SETTLE = 4;
  localparam int LOCKN  = 8;
  localparam int ERRN   = 2;

  logic clock = 1'b0;
  logic reset_i = 1'b1;

  sof_tap_scanner_if ifc();

  sof_tap_scanner #(
    .SETTLE_CYCLES(SETTLE),
    .LOCK_COUNT(LOCKN),
    .ERR_THRESH(ERRN)
  ) dut (
    .clock(clock),
    .reset_i(reset_i),
    .bus(ifc)
  );

  always #10 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0 idle, 1 waiting, 2 counting hits, 3 locked
  int m_state, m_tap, m_settle_left, m_good, m_err, m_tries, m_fail, m_relocks, m_hold;

  function automatic logic [15:0] mv();
    logic [15:0] v;
    v = {2'(m_state), 4'(m_tap), (m_state == 3), 1'(m_fail), 8'(m_relocks)};
    return v;
  endfunction

  function automatic logic [15:0] dv();
    return {ifc.state, ifc.tap, ifc.locked, ifc.scan_fail, ifc.relock_cnt};
  endfunction

  task automatic model_clear();
    m_state = 0; m_tap = 0; m_settle_left = 0; m_good = 0; m_err = 0;
    m_tries = 0; m_fail = 0; m_relocks = 0; m_hold = 2;
  endtask

  task automatic leave_lock_to(input int new_tap);
    if (m_state == 3 && m_relocks < 255) m_relocks++;
    m_tap = new_tap % 16;
    m_state = 1;
    m_settle_left = SETTLE;
    m_good = 0;
    m_err = 0;
  endtask

  task automatic model_step();
    if (!ifc.enable) begin
      m_state = 0; m_tap = 0; m_good = 0; m_err = 0; m_tries = 0; m_fail = 0;
    end else if (ifc.force_tap_en) begin
      leave_lock_to(int'(ifc.force_tap));
    end else if (m_state == 0) begin
      m_state = 1; m_settle_left = SETTLE;
    end else if (m_state == 1) begin
      m_settle_left--;
      if (m_settle_left == 0) begin m_state = 2; m_good = 0; end
    end else if (m_state == 2) begin
      if (ifc.sof_aligned) begin
        m_good++;
        if (m_good == LOCKN) begin m_state = 3; m_fail = 0; m_tries = 0; m_err = 0; end
      end else begin
        m_tries++;
        if (m_tries == 16) begin m_fail = 1; m_tries = 0; end
        m_tap = (m_tap + 1) % 16;
        m_state = 1; m_settle_left = SETTLE; m_good = 0;
      end
    end else begin
      if (ifc.relock_req || (!ifc.sof_aligned && m_err + 1 >= ERRN)) leave_lock_to(m_tap + 1);
      else if (!ifc.sof_aligned) m_err++;
      else m_err = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_i) model_clear();
    else if (m_hold > 0) m_hold--;
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    ifc.enable = 1'b0; ifc.sof_aligned = 1'b0; ifc.force_tap_en = 1'b0;
    ifc.force_tap = 4'd0; ifc.relock_req = 1'b0;
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dv() !== 16'h0000) begin
      miscompares++; $display("FAIL reset_state: got %h exp 0000", dv());
    end
    ifc.enable = 1'b1;
    tick();
    vectors++;
    if (ifc.state !== 2'd1 || ifc.tap !== 4'd0) begin
      miscompares++; $display("FAIL reset_first_step: state %0d tap %0d exp 1/0", ifc.state, ifc.tap);
    end
  endtask

  task automatic test_basic_lock();
    do_reset();
    ifc.sof_aligned = 1'b1; ifc.enable = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL basic_lock c%0d: got %h exp %h", i, dv(), mv()); end
      if (i == 4 || i == 12) begin
        vectors++;
        if (ifc.state !== ((i == 4) ? 2'd1 : 2'd2) || ifc.locked !== 1'b0) begin
          miscompares++; $display("FAIL basic_lock_phase c%0d: state %0d locked %b", i, ifc.state, ifc.locked);
        end
      end
    end
    vectors++;
    if ({ifc.state, ifc.locked, ifc.tap} !== {2'd3, 1'b1, 4'd0}) begin
      miscompares++; $display("FAIL basic_lock_c13: got %h exp 7_0", {ifc.state, ifc.locked, ifc.tap});
    end
  endtask

  task automatic test_tap5();
    do_reset();
    ifc.enable = 1'b1;
    for (int i = 0; i < 200 && m_state != 3; i++) begin
      ifc.sof_aligned = (m_tap == 5);
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL tap5 c%0d: got %h exp %h", i, dv(), mv()); end
    end
    vectors++;
    if ({ifc.tap, ifc.locked, ifc.scan_fail, ifc.relock_cnt} !== {4'd5, 1'b1, 1'b0, 8'd0}) begin
      miscompares++; $display("FAIL tap5_lock: tap %0d locked %b fail %b relocks %0d", ifc.tap, ifc.locked, ifc.scan_fail, ifc.relock_cnt);
    end
  endtask

  task automatic test_scan_fail();
    do_reset();
    ifc.enable = 1'b1; ifc.sof_aligned = 1'b0;
    for (int i = 1; i <= 81; i++) begin
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL scan_fail c%0d: got %h exp %h", i, dv(), mv()); end
      if (i == 76) begin
        vectors++;
        if (ifc.scan_fail !== 1'b0 || ifc.tap !== 4'd15) begin
          miscompares++; $display("FAIL scan_fail_pre: fail %b tap %0d exp 0/15", ifc.scan_fail, ifc.tap);
        end
      end
    end
    vectors++;
    if ({ifc.scan_fail, ifc.tap, ifc.state} !== {1'b1, 4'd0, 2'd1}) begin
      miscompares++; $display("FAIL scan_fail_set: fail %b tap %0d state %0d exp 1/0/1", ifc.scan_fail, ifc.tap, ifc.state);
    end
    ifc.sof_aligned = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL scan_relock c%0d: got %h exp %h", i, dv(), mv()); end
    end
    vectors++;
    if ({ifc.locked, ifc.scan_fail, ifc.tap} !== {1'b1, 1'b0, 4'd0}) begin
      miscompares++; $display("FAIL scan_fail_clear: locked %b fail %b tap %0d", ifc.locked, ifc.scan_fail, ifc.tap);
    end
  endtask

  task automatic test_errors();
    logic [1:0] pat [4];
    do_reset();
    ifc.enable = 1'b1;
    for (int i = 0; i < 200 && m_state != 3; i++) begin
      ifc.sof_aligned = (m_tap == 3);
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL err_scan c%0d: got %h exp %h", i, dv(), mv()); end
    end
    pat[0] = 2'b0; pat[1] = 2'b1; pat[2] = 2'b0; pat[3] = 2'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.sof_aligned = pat[i][0];
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL err_seq c%0d: got %h exp %h", i, dv(), mv()); end
      if (i == 1) begin
        vectors++;
        if (ifc.locked !== 1'b1 || ifc.tap !== 4'd3) begin
          miscompares++; $display("FAIL err_single_miss: locked %b tap %0d exp 1/3", ifc.locked, ifc.tap);
        end
      end
    end
    vectors++;
    if ({ifc.state, ifc.tap, ifc.locked, ifc.relock_cnt} !== {2'd1, 4'd4, 1'b0, 8'd1}) begin
      miscompares++; $display("FAIL err_double_miss: state %0d tap %0d locked %b relocks %0d", ifc.state, ifc.tap, ifc.locked, ifc.relock_cnt);
    end
  endtask

  task automatic test_force();
    do_reset();
    ifc.enable = 1'b1; ifc.sof_aligned = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    ifc.force_tap_en = 1'b1; ifc.force_tap = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL force_hold c%0d: got %h exp %h", i, dv(), mv()); end
    end
    vectors++;
    if ({ifc.locked, ifc.tap, ifc.state, ifc.relock_cnt} !== {1'b0, 4'd9, 2'd1, 8'd1}) begin
      miscompares++; $display("FAIL force_apply: locked %b tap %0d state %0d relocks %0d", ifc.locked, ifc.tap, ifc.state, ifc.relock_cnt);
    end
    ifc.force_tap_en = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL force_release c%0d: got %h exp %h", i, dv(), mv()); end
      if (i == 11) begin
        vectors++;
        if (ifc.locked !== 1'b0) begin miscompares++; $display("FAIL force_early_lock: locked %b exp 0", ifc.locked); end
      end
    end
    vectors++;
    if ({ifc.locked, ifc.tap} !== {1'b1, 4'd9}) begin
      miscompares++; $display("FAIL force_lock: locked %b tap %0d exp 1/9", ifc.locked, ifc.tap);
    end
  endtask

  task automatic test_async_reset_and_saturation();
    do_reset();
    ifc.enable = 1'b1;
    for (int i = 0; i < 300 && !(m_state == 2 && m_tap == 7 && m_good == 3); i++) begin
      ifc.sof_aligned = (m_tap == 7);
      tick();
    end
    vectors++;
    if (ifc.state !== 2'd2 || ifc.tap !== 4'd7) begin
      miscompares++; $display("FAIL mid_check_reach: state %0d tap %0d exp 2/7", ifc.state, ifc.tap);
    end
    #3 reset_i = 1'b1;
    #1;
    vectors++;
    if (dv() !== 16'h0000) begin miscompares++; $display("FAIL async_reset: got %h exp 0000", dv()); end
    tick(); tick();
    reset_i = 1'b0;
    ifc.sof_aligned = 1'b1;
    for (int i = 0; i < 3420; i++) begin
      ifc.relock_req = (m_state == 3);
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL saturate c%0d: got %h exp %h", i, dv(), mv()); end
    end
    ifc.relock_req = 1'b0;
    vectors++;
    if (ifc.relock_cnt !== 8'd255) begin
      miscompares++; $display("FAIL relock_saturate: got %0d exp 255", ifc.relock_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ifc.enable       = ($urandom_range(0, 63) != 0);
      ifc.force_tap_en = ($urandom_range(0, 39) == 0);
      ifc.force_tap    = 4'($urandom_range(0, 15));
      ifc.relock_req   = ($urandom_range(0, 19) == 0);
      ifc.sof_aligned  = ($urandom_range(0, 7) != 0);
      tick();
      vectors++;
      if (dv() !== mv()) begin miscompares++; $display("FAIL random c%0d: got %h exp %h", i, dv(), mv()); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_lock();
    test_tap5();
    test_scan_fail();
    test_errors();
    test_force();
    test_async_reset_and_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
